load_store_unit: RTL

Multi-cycle load/store unit sitting directly downstream of the ALU. It takes `ALUResult` as the effective address and the rt register value as store data. It performs byte, halfword or word accesses over a req/ack data-memory bus and returns aligned, extended load data to the register-file write-back mux. While an access is in flight it holds the core via `Stall`.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/lsu_align.sv | 30 +++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared memory-access encodings, LSU state enum and alignment helper
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Half needs addr[0]=0, word (and the 11 encoding) needs addr[1:0]=0
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_BYTE) ? 1'b0 : (size == SZ_HALF) ? a[0] : (a != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable generation, store-lane replication and load-lane extraction
module lsu_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_addr,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Steer stores onto lanes and pull the addressed load lane down to bit 0
    always_comb begin
        st_be    = (st_size == SZ_BYTE) ? 4'b0001 << st_addr :
                   (st_size == SZ_HALF) ? 4'b0011 << st_addr : 4'b1111;
        st_lanes = (st_size == SZ_BYTE) ? {4{st_data[7:0]}} :
                   (st_size == SZ_HALF) ? {2{st_data[15:0]}} : st_data;
        shifted  = ld_rdata >> {ld_addr, 3'b000};
        ld_data  = (ld_size == SZ_BYTE) ? {{24{ld_signed & shifted[7]}}, shifted[7:0]} :
                   (ld_size == SZ_HALF) ? {{16{ld_signed & shifted[15]}}, shifted[15:0]} : ld_rdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle req/ack load/store unit; LSU_TIMEOUT_EN adds a bus timeout
module load_store_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            MemSize,
    input  logic                  MemSigned,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  AddrErr,
    output logic                  BusFault,
    output logic                  BusReq,
    output logic                  BusWe,
    output logic [DATA_WIDTH-1:0] BusAddr,
    output logic [3:0]            BusBe,
    output logic [DATA_WIDTH-1:0] BusWData,
    input  logic [DATA_WIDTH-1:0] BusRData,
    input  logic                  BusAck
);

    lsu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]            size_q, size_d;
    logic [3:0]            be_q, be_d;
    logic                  sgn_q, sgn_d, we_q, we_d, addr_err_q, addr_err_d;
    logic                  req, mis;
    logic [3:0]            st_be;
    logic [31:0]           st_lanes, ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_fault_q, bus_fault_d;
`else
    logic             unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign req = MemRead | MemWrite;
    assign mis = misaligned(MemSize, ALUResult[1:0]);

    lsu_align u_align (
        .st_addr   (ALUResult[1:0]),
        .st_size   (MemSize),
        .st_data   (WriteData),
        .st_be     (st_be),
        .st_lanes  (st_lanes),
        .ld_addr   (addr_q[1:0]),
        .ld_size   (size_q),
        .ld_signed (sgn_q),
        .ld_rdata  (BusRData),
        .ld_data   (ld_data)
    );

    // Next-state: latch the request in IDLE, wait for ack (or timeout) in REQ, retire in DONE
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        addr_err_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_fault_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (req) begin
                addr_d     = ALUResult;
                size_d     = MemSize;
                sgn_d      = MemSigned;
                we_d       = MemWrite;
                be_d       = st_be;
                wdata_d    = st_lanes;
                addr_err_d = mis;
                rdata_d    = (mis && !MemWrite) ? '0 : rdata_q;
                state_d    = mis ? DONE : REQ;
`ifdef LSU_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            REQ: if (BusAck) begin
                rdata_d = we_q ? rdata_q : ld_data;
                state_d = DONE;
            end
`ifdef LSU_TIMEOUT_EN
            else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    bus_fault_d = 1'b1;
                    rdata_d     = we_q ? rdata_q : '0;
                    state_d     = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and latched access registers; reset abandons any bus transaction
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Wait counter and fault pulse
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q       <= '0;
            bus_fault_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bus_fault_q <= bus_fault_d;
        end
    end
    assign BusFault = bus_fault_q;
`else
    assign BusFault = 1'b0;
`endif

    assign Stall    = (state_q == REQ) | ((state_q == IDLE) & req);
    assign BusReq   = (state_q == REQ);
    assign BusWe    = we_q;
    assign BusAddr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign BusBe    = be_q;
    assign BusWData = wdata_q;
    assign ReadData = rdata_q;
    assign AddrErr  = addr_err_q;

endmodule
